// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Ceiling log2 with a floor of 1 so every derived vector has at least one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: toggles every CLK_DIV cycles while enabled, parks at CPOL otherwise,
// and flags the clk edge on which each sclk transition happens.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int   CLK_DIV = 1,
  parameter logic CPOL    = 1'b0,
  parameter logic CPHA    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb,
  output logic sample_stb,
  output logic shift_stb
);

  localparam int              DIV_W          = clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
  localparam logic [1:0]      MODE           = {CPOL, CPHA};
  localparam bit              SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;
  logic             tick;

  assign tick = en && (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt_reg <= '0;
      sclk_reg    <= CPOL;
    end else if (tick) begin
      div_cnt_reg <= '0;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Strobes are high in the cycle that ends with the matching sclk transition.
  assign lead_stb   = tick && (sclk_reg == CPOL);
  assign trail_stb  = tick && (sclk_reg != CPOL);
  assign sample_stb = SAMPLE_ON_LEAD ? lead_stb : trail_stb;
  assign shift_stb  = SAMPLE_ON_LEAD ? trail_stb : lead_stb;
  assign sclk       = sclk_reg;

endmodule

// File: rtl/spi_main_param.sv
// Parametrised SPI master: frame FSM, tx/rx shift registers and chip-select decoder.
// One frame is SETUP + N sclk periods + HOLD, followed by an optional cs_n-high gap.
module spi_main_param
  import spi_pkg::*;
#(
  parameter int   TX_WIDTH = 258,
  parameter int   RX_WIDTH = 128,
  parameter int   CLK_DIV  = 1,
  parameter logic CPOL     = 1'b0,
  parameter logic CPHA     = 1'b0,
  parameter int   NUM_CS   = 1,
  parameter int   CS_GAP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [clog2(NUM_CS)-1:0]   cs_sel,
  input  logic [TX_WIDTH-1:0]        tx,
  input  logic                       miso,
  output logic [RX_WIDTH-1:0]        rx,
  output logic [NUM_CS-1:0]          cs_n,
  output logic                       sclk,
  output logic                       mosi,
  output logic                       busy,
  output logic                       done
);

  localparam int               SEL_W    = clog2(NUM_CS);
  localparam int               BIT_W    = clog2(TX_WIDTH + 1);
  localparam int               DIV_W    = clog2(CLK_DIV + 1);
  localparam int               GAP_W    = clog2(CS_GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TX_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  spi_state_t          state_reg, state_next;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [TX_WIDTH-1:0] tx_sr_reg;
  logic [RX_WIDTH-1:0] rx_sr_reg;
  logic [RX_WIDTH-1:0] rx_reg;
  logic [NUM_CS-1:0]   cs_n_reg;
  logic [NUM_CS-1:0]   cs_dec;
  logic                mosi_reg;
  logic                done_reg;
  logic                sclk_en;
  logic                lead_stb, trail_stb, sample_stb, shift_stb;
  logic                accept, phase_end, last_trail, complete;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL),
    .CPHA    (CPHA)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (sclk_en),
    .sclk       (sclk),
    .lead_stb   (lead_stb),
    .trail_stb  (trail_stb),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  assign accept     = (state_reg == IDLE) && start;
  assign phase_end  = (div_cnt_reg == DIV_LAST);
  // bit_cnt_reg counts leading edges, so the Nth trailing edge closes the frame.
  assign last_trail = trail_stb && (bit_cnt_reg == BIT_LAST);
  assign complete   = (state_reg == HOLD) && phase_end;

  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign cs_dec[gi] = (cs_sel != SEL_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start)      state_next = SETUP;
      SETUP:   if (phase_end)  state_next = SHIFT;
      SHIFT:   if (last_trail) state_next = HOLD;
      HOLD:    if (phase_end)  state_next = (CS_GAP == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != IDLE);
    sclk_en = (state_reg == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      bit_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= ((state_reg == SETUP || state_reg == HOLD) && !phase_end)
                     ? div_cnt_reg + 1'b1 : '0;
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 1'b1 : '0;
      if (state_reg != SHIFT) begin
        bit_cnt_reg <= '0;
      end else if (lead_stb) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_reg <= '0;
      rx_sr_reg <= '0;
      rx_reg    <= '0;
      cs_n_reg  <= '1;
      mosi_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        cs_n_reg <= cs_dec;
        // CPHA=0 presents the MSB before the first edge; CPHA=1 shifts it out on that edge.
        if (CPHA) begin
          tx_sr_reg <= tx;
          mosi_reg  <= 1'b0;
        end else begin
          tx_sr_reg <= tx << 1;
          mosi_reg  <= tx[TX_WIDTH-1];
        end
      end else if (state_reg == SHIFT) begin
        if (sample_stb) begin
          rx_sr_reg <= (rx_sr_reg << 1) | RX_WIDTH'(miso);
        end
        if (shift_stb && !last_trail) begin
          mosi_reg  <= tx_sr_reg[TX_WIDTH-1];
          tx_sr_reg <= tx_sr_reg << 1;
        end
      end else if (complete) begin
        cs_n_reg <= '1;
        mosi_reg <= 1'b0;
        rx_reg   <= rx_sr_reg;
        done_reg <= 1'b1;
      end
    end
  end

  assign rx   = rx_reg;
  assign cs_n = cs_n_reg;
  assign mosi = mosi_reg;
  assign done = done_reg;

endmodule
